// File: rtl/boot_mem_responder.sv
// Byte-wide RAM responder for the 8-bit core bus with a length-prefixed
// byte-stream boot loader that holds the core in reset until the image is in.
module boot_mem_responder #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] LOAD_BASE = '0,
    parameter bit                BOOT_SKIP = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] core_address,
    input  logic [7:0]  core_out,
    input  logic        core_wren,
    output logic [7:0]  core_data,
    output logic        core_rst_n,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    output logic        ld_ready,
    output logic [7:0]  ld_sum,
    output logic        ld_done
);

    typedef enum logic [1:0] {
        HDR_LO,
        HDR_HI,
        LOAD,
        RUN
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t            r_state;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_sum;
    logic              r_ready;
    logic              r_done;
    logic              r_core_rst_n;
    logic [7:0]        r_core_data;
    logic [7:0]        r_ram [DEPTH];

    state_t            w_state_nxt;
    logic [15:0]       w_len_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [7:0]        w_sum_nxt;
    logic              w_ld_we;
    logic              w_hs;
    logic [ADDR_W-1:0] w_idx;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [7:0]        w_ram_wdata;
    logic              w_unused_addr;

    // Upper core address bits are dropped so the RAM mirrors across 1 MB.
    assign w_idx         = core_address[ADDR_W-1:0];
    assign w_unused_addr = ^core_address[19:ADDR_W];
    assign w_hs          = ld_valid & r_ready;

    // NOTE: every comb output gets a default first so no path leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_ptr_nxt   = r_ptr;
        w_sum_nxt   = r_sum;
        w_ld_we     = 1'b0;
        case (r_state)
            HDR_LO: begin
                if (w_hs) begin
                    w_len_nxt[7:0] = ld_byte;
                    w_state_nxt    = HDR_HI;
                end
            end
            HDR_HI: begin
                if (w_hs) begin
                    w_len_nxt[15:8] = ld_byte;
                    w_ptr_nxt       = LOAD_BASE;
                    w_sum_nxt       = 8'h00;
                    w_state_nxt     = ({ld_byte, r_len[7:0]} == 16'd0) ? RUN : LOAD;
                end
            end
            LOAD: begin
                if (w_hs) begin
                    w_ld_we   = 1'b1;
                    w_ptr_nxt = r_ptr + ADDR_W'(1);
                    w_sum_nxt = r_sum + ld_byte;
                    w_len_nxt = r_len - 16'd1;
                    if (r_len == 16'd1) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = HDR_LO;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= BOOT_SKIP ? RUN : HDR_LO;
            r_len        <= 16'd0;
            r_ptr        <= LOAD_BASE;
            r_sum        <= 8'h00;
            r_ready      <= 1'b0;
            r_done       <= 1'b0;
            r_core_rst_n <= BOOT_SKIP;
            r_core_data  <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_len        <= w_len_nxt;
            r_ptr        <= w_ptr_nxt;
            r_sum        <= w_sum_nxt;
            r_ready      <= (w_state_nxt != RUN);
            r_done       <= (w_state_nxt == RUN) && (r_state != RUN);
            r_core_rst_n <= (r_state == RUN);
            r_core_data  <= r_ram[w_idx];
        end
    end

    // Single write port: loader owns it during LOAD, the core only in RUN.
    assign w_ram_we    = w_ld_we | (core_wren & (r_state == RUN));
    assign w_ram_addr  = w_ld_we ? r_ptr : w_idx;
    assign w_ram_wdata = w_ld_we ? ld_byte : core_out;

    // NOTE: the RAM array has no reset; contents survive reset by design.
    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_ram[w_ram_addr] <= w_ram_wdata;
        end
    end

    assign core_data  = r_core_data;
    assign core_rst_n = r_core_rst_n;
    assign ld_ready   = r_ready;
    assign ld_sum     = r_sum;
    assign ld_done    = r_done;

endmodule
